// File: rtl/radix4_booth_iter_mult_if.sv
// radix4_booth_iter_mult_if: operand/result valid-ready handshake bundle for the iterative Booth multiplier
interface radix4_booth_iter_mult_if #(parameter int W = 32);
  logic in_valid;
  logic in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic out_valid;
  logic out_ready;
  logic [2*W-1:0] p;
  logic busy;
  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, p, busy);
  modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, p, busy);
endinterface

// File: rtl/radix4_booth_iter_mult.sv
// radix4_booth_iter_mult: unsigned radix-4 Booth multiplier retiring one digit per clock; define APPROX_EN to truncate the low APPROX_K columns
module radix4_booth_iter_mult #(
  parameter int W = 32,
  parameter int APPROX_K = 16
) (
  input logic clk,
  input logic rst,
  radix4_booth_iter_mult_if.slave bus
);
  localparam int N = W / 2 + 1;
  localparam int AW = 2 * W + 2;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0] r_state;
  logic [W-1:0] r_a;
  logic [W+2:0] r_bx;
  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic [2*W-1:0] r_p;
  logic r_out_valid;
  logic [2:0] w_dig;
  logic [AW-1:0] w_a1;
  logic [AW-1:0] w_pp;
  logic [AW-1:0] w_pps;
  logic [AW-1:0] w_acc_nxt;
  // r_bx holds {00, b, b[-1]=0}, so digit i sits at bits [2i+2:2i]
  assign w_dig = 3'(r_bx >> {r_cnt, 1'b0});
  assign w_a1 = AW'(r_a);
  always_comb begin
    w_pp = (w_dig == 3'd1 || w_dig == 3'd2) ? w_a1 :
           (w_dig == 3'd3) ? (w_a1 << 1) :
           (w_dig == 3'd4) ? -(w_a1 << 1) :
           (w_dig == 3'd5 || w_dig == 3'd6) ? -w_a1 : '0;
    w_pps = w_pp << {r_cnt, 1'b0};
  end
`ifdef APPROX_EN
  localparam logic [AW-1:0] MASK = {AW{1'b1}} << APPROX_K;
  assign w_acc_nxt = r_acc + (w_pps & MASK);
`else
  assign w_acc_nxt = r_acc + w_pps;
`endif
  assign bus.in_ready = (r_state == S_IDLE);
  assign bus.busy = (r_state != S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.p = r_p;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a <= '0;
      r_bx <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_p <= '0;
      r_out_valid <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (bus.in_valid) begin
        r_a <= bus.a;
        r_bx <= {2'b00, bus.b, 1'b0};
        r_acc <= '0;
        r_cnt <= '0;
        r_state <= S_RUN;
      end
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST) begin
        r_p <= w_acc_nxt[2*W-1:0];
        r_out_valid <= 1'b1;
        r_state <= S_DONE;
      end
    end else if (r_state == S_DONE) begin
      if (bus.out_ready) begin
        r_out_valid <= 1'b0;
        r_state <= S_IDLE;
      end
    end else begin
      r_state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_radix4_booth_iter_mult.sv
// tb_radix4_booth_iter_mult: directed vector table plus handshake, backpressure and reset sequences
module tb_radix4_booth_iter_mult;
  localparam int W = 32;
  localparam int K = 16;
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2*W-1:0] p;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errs = 0;
  radix4_booth_iter_mult_if #(.W(W)) bus();
  radix4_booth_iter_mult #(.W(W), .APPROX_K(K)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = ~a;
    bus.b = ~b;
  endtask
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask
  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output logic [2*W-1:0] p, output int lat);
    start(a, b);
    wait_valid(lat);
    p = bus.p;
    drain();
  endtask
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
    logic [2*W+1:0] acc, pp, am, mask;
    logic [W+2:0] bx;
    logic [2:0] d;
    acc = '0;
    am = {34'd0, a};
    bx = {2'b00, b, 1'b0};
    mask = {(2*W+2){1'b1}} << k;
    for (int i = 0; i < W / 2 + 1; i++) begin
      d = bx[2*i +: 3];
      case (d)
        3'd1, 3'd2: pp = am;
        3'd3: pp = am << 1;
        3'd4: pp = -(am << 1);
        3'd5, 3'd6: pp = -am;
        default: pp = '0;
      endcase
      acc = acc + ((pp << (2 * i)) & mask);
    end
    return acc[2*W-1:0];
  endfunction
  initial begin
    vec_t tbl[8];
    logic [2*W-1:0] p, p0, ex;
    logic [W-1:0] ra, rb;
    int lat;
    bit seen;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b0;
    tbl[0] = '{32'd65541, 32'd150, 64'd9831150};
    tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    tbl[2] = '{32'd0, 32'h12345678, 64'd0};
    tbl[3] = '{32'd3, 32'd5, 64'd15};
    tbl[4] = '{32'd12345, 32'd6789, 64'd83810205};
    tbl[5] = '{32'h80000000, 32'd2, 64'h100000000};
    tbl[6] = '{32'hFFFFFFFF, 32'h80000000, 64'h7FFFFFFF80000000};
    tbl[7] = '{32'hFFFFFFFF, 32'd1, 64'h00000000FFFFFFFF};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_p", bus.p, 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
`ifndef APPROX_EN
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, p, lat);
      chk($sformatf("vec%0d_p", i), p, tbl[i].p);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd17);
    end
    start(32'd1000, 32'd1000);
    repeat (3) @(negedge clk);
    chk("run_busy", 64'(bus.busy), 64'd1);
    chk("run_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    bus.a = 32'd7;
    bus.b = 32'd9;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    wait_valid(lat);
    chk("bp_latency", 64'(lat), 64'd13);
    p0 = bus.p;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_p_stable", bus.p, p0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    chk("bp_p", bus.p, 64'd1000000);
    drain();
    chk("bp_done_out_valid", 64'(bus.out_valid), 64'd0);
    chk("bp_done_in_ready", 64'(bus.in_ready), 64'd1);
    start(32'd100, 32'd100);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen |= bus.out_valid;
    end
    chk("abort_no_out_valid", 64'(seen), 64'd0);
    run_op(32'd3, 32'd5, p, lat);
    chk("after_abort_p", p, 64'd15);
    chk("after_abort_latency", 64'(lat), 64'd17);
`else
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, p, lat);
    ex = 64'hFFFFFFFE00000001;
    chk("approx_low_zero", 64'(p[K-1:0]), 64'd0);
    chk("approx_upper_bound", 64'(p <= ex), 64'd1);
    chk("approx_lower_bound", 64'(p > ex - 64'(17 * 65536)), 64'd1);
    chk("approx_model", p, model(32'hFFFFFFFF, 32'hFFFFFFFF, K));
    chk("approx_latency", 64'(lat), 64'd17);
    for (int i = 0; i < 2000; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op(ra, rb, p, lat);
      chk("approx_rand", p, model(ra, rb, K));
    end
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
